uart_receiver: RTL and testbench

- Serial-to-parallel UART receive stage: 8N1-style frames (1 start, DATA_WIDTH data bits LSB-first, 1 stop) in on RXD, one parallel word plus a one-cycle valid strobe out.
- Sits at the board RX pin, directly upstream of the consumer logic (loopback checker, command decoder, FIFO).
- Uses 16x oversampling with mid-bit sampling and start-bit glitch rejection.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_receiver_if.sv | 12 +
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_receiver.sv | 153 +++++++++++++++
 tb/tb_uart_receiver.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, one-hot receiver state encoding and divider helper
package uart_pkg;

   localparam int DEFAULT_CLK_FREQ   = 100000000;
   localparam int DEFAULT_BAUD       = 115200;
   localparam int DEFAULT_OVERSAMPLE = 16;
   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int STATE_W            = 5;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 5'b00001,
      ST_START     = 5'b00010,
      ST_DATA      = 5'b00100,
      ST_STOP      = 5'b01000,
      ST_WAIT_HIGH = 5'b10000
   } state_e;

   // Rounded clocks-per-oversample-tick.
   function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
      int tick_rate;
      tick_rate = baud * oversample;
      return (clk_freq + tick_rate / 2) / tick_rate;
   endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - parallel output bundle of the UART receiver
interface uart_receiver_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  frame_err;
   logic                  busy;

   modport master (output data, output valid, output frame_err, output busy);
   modport slave  (input  data, input  valid, input  frame_err, input  busy);
endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, cleared and held while disabled
module uart_baud_tick #(
   parameter int DIV = 54
) (
   input  logic CLK100MHZ,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (!enable || cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign tick = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x oversampled UART receive stage with start-glitch rejection
module uart_receiver
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int CLK_FREQ    = DEFAULT_CLK_FREQ,
   parameter int BAUD        = DEFAULT_BAUD,
   parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
   parameter int SYNC_STAGES = 2
) (
   input  logic            CLK100MHZ,
   input  logic            reset,
   input  logic            RXD,
   uart_receiver_if.master rx_if
);

   localparam int DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int SC_W  = $clog2(OVERSAMPLE);
   localparam int BIT_W = $clog2(DATA_WIDTH + 1);

   localparam logic [SC_W-1:0]  SC_MID   = SC_W'(OVERSAMPLE / 2 - 1);
   localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs;
   state_e                 state_q, state_d;
   logic [SC_W-1:0]        sc_q, sc_d;
   logic [BIT_W-1:0]       bit_q, bit_d;
   logic [DATA_WIDTH-1:0]  shift_q, shift_d;
   logic [DATA_WIDTH-1:0]  data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   ferr_q, ferr_d;
   logic                   tick_en;
   logic                   tick;

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], RXD};
      end
   end

   assign rxs = sync_q[SYNC_STAGES-1];

   // No ticks in IDLE/WAIT_HIGH, so every frame starts its bit timing from the start edge.
   assign tick_en = (state_q != ST_IDLE) && (state_q != ST_WAIT_HIGH);

   uart_baud_tick #(
      .DIV(DIV)
   ) u_baud_tick (
      .CLK100MHZ(CLK100MHZ),
      .reset    (reset),
      .enable   (tick_en),
      .tick     (tick)
   );

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sc_q    <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sc_q    <= sc_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sc_d    = sc_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!rxs) begin
               state_d = ST_START;
               sc_d    = '0;
               bit_d   = '0;
            end
         end
         ST_START: begin
            if (tick) begin
               if (sc_q == SC_MID) begin
                  sc_d    = '0;
                  state_d = rxs ? ST_IDLE : ST_DATA;
               end else begin
                  sc_d = sc_q + 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (sc_q == SC_LAST) begin
                  shift_d = {rxs, shift_q[DATA_WIDTH-1:1]};
                  sc_d    = '0;
                  bit_d   = bit_q + 1'b1;
                  if (bit_q == BIT_LAST) begin
                     state_d = ST_STOP;
                  end
               end else begin
                  sc_d = sc_q + 1'b1;
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (sc_q == SC_LAST) begin
                  sc_d = '0;
                  // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
                  if (rxs) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = ST_WAIT_HIGH;
                  end
               end else begin
                  sc_d = sc_q + 1'b1;
               end
            end
         end
         ST_WAIT_HIGH: begin
            if (rxs) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign rx_if.data      = data_q;
   assign rx_if.valid     = valid_q;
   assign rx_if.frame_err = ferr_q;
   assign rx_if.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench with an event-queue model of the receiver
module tb_uart_receiver;
   import uart_pkg::*;

   // Bench runs the line at 230400 bit/s to keep the run short: DIV = 27, DUT bit = 432 clk.
   localparam int TB_BAUD = 230400;
   localparam int BIT_CLK = 434;
   localparam int LAT     = 4106;
   localparam int LAT_TOL = 2;
   localparam int B2B     = 4320;
   localparam int B2B_TOL = 32;
   localparam int BUSY_MAX = 220;

   typedef struct {
      bit          is_err;
      logic [7:0]  b;
      longint      t_fall;
   } ev_t;

   logic   CLK100MHZ = 1'b0;
   logic   reset     = 1'b1;
   logic   RXD       = 1'b1;
   longint cyc       = 0;
   int     total     = 0;
   int     bad       = 0;
   ev_t    exp_q[$];
   longint vt_q[$];
   logic [7:0] model_data = 8'h00;

   uart_receiver_if #(.DATA_WIDTH(8)) rx_if ();

   uart_receiver #(
      .DATA_WIDTH (8),
      .CLK_FREQ   (100000000),
      .BAUD       (TB_BAUD),
      .OVERSAMPLE (16),
      .SYNC_STAGES(2)
   ) dut (
      .CLK100MHZ(CLK100MHZ),
      .reset    (reset),
      .RXD      (RXD),
      .rx_if    (rx_if)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   initial begin
      forever begin
         @(posedge CLK100MHZ);
         cyc = cyc + 1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Drives one frame starting at the next falling clock edge; optionally registers the expected outcome.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bclk, input bit push);
      ev_t e;
      @(negedge CLK100MHZ);
      RXD = 1'b0;
      if (push) begin
         e.is_err = !stop_bit;
         e.b      = b;
         e.t_fall = cyc;
         exp_q.push_back(e);
      end
      repeat (bclk - 1) @(negedge CLK100MHZ);
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK100MHZ);
         RXD = b[i];
         repeat (bclk - 1) @(negedge CLK100MHZ);
      end
      @(negedge CLK100MHZ);
      RXD = stop_bit;
      repeat (bclk - 1) @(negedge CLK100MHZ);
   endtask

   task automatic idle(input int n);
      RXD = 1'b1;
      repeat (n) @(negedge CLK100MHZ);
   endtask

   // Compare process: every output event must match the head of the expected queue, on time.
   initial begin
      ev_t ev;
      forever begin
         @(negedge CLK100MHZ);
         if (reset) begin
            model_data = 8'h00;
         end else begin
            check("valid_ferr_exclusive", rx_if.valid & rx_if.frame_err, 1'b0);
            if (rx_if.valid || rx_if.frame_err) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_event", {rx_if.valid, rx_if.frame_err}, 2'b00);
               end else begin
                  ev = exp_q.pop_front();
                  check("event_kind_ferr", rx_if.frame_err, ev.is_err);
                  check_range("event_latency", cyc - ev.t_fall, LAT - LAT_TOL, LAT + LAT_TOL);
                  if (!ev.is_err) model_data = ev.b;
                  if (rx_if.valid) vt_q.push_back(cyc);
               end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].t_fall + LAT + LAT_TOL) begin
               total++;
               bad++;
               $display("FAIL missing_event: no output by cycle %0d for byte %0h", cyc, exp_q[0].b);
               void'(exp_q.pop_front());
            end
            check("data_hold", rx_if.data, model_data);
         end
      end
   end

   initial begin
      longint t0;

      // Divider pins: defaults and bench configuration.
      check("div_default", calc_div(100000000, 115200, 16), 54);
      check("div_bench", calc_div(100000000, TB_BAUD, 16), 27);

      repeat (5) @(negedge CLK100MHZ);
      check("rst_data", rx_if.data, 8'h00);
      check("rst_valid", rx_if.valid, 1'b0);
      check("rst_ferr", rx_if.frame_err, 1'b0);
      check("rst_busy", rx_if.busy, 1'b0);
      reset = 1'b0;
      idle(BIT_CLK);

      // Single frame
      send_frame(8'hA5, 1'b1, BIT_CLK, 1'b1);
      idle(BIT_CLK);
      check("single_a5", rx_if.data, 8'hA5);

      // Glitch rejection
      @(negedge CLK100MHZ);
      RXD = 1'b0;
      t0 = cyc;
      repeat (10) @(negedge CLK100MHZ);
      check("glitch_busy_high", rx_if.busy, 1'b1);
      repeat (190) @(negedge CLK100MHZ);
      RXD = 1'b1;
      while (cyc < t0 + BUSY_MAX) @(negedge CLK100MHZ);
      check("glitch_busy_drop", rx_if.busy, 1'b0);
      idle(BIT_CLK);
      send_frame(8'h3C, 1'b1, BIT_CLK, 1'b1);
      idle(BIT_CLK);
      check("after_glitch_3c", rx_if.data, 8'h3C);

      // Framing error followed by a held-low line
      send_frame(8'h11, 1'b1, BIT_CLK, 1'b1);
      send_frame(8'h3C, 1'b0, BIT_CLK, 1'b1);
      repeat (4 * BIT_CLK) @(negedge CLK100MHZ);
      check("break_busy", rx_if.busy, 1'b1);
      check("ferr_data_kept", rx_if.data, 8'h11);
      idle(BIT_CLK);
      send_frame(8'h77, 1'b1, BIT_CLK, 1'b1);
      idle(BIT_CLK);
      check("after_ferr_77", rx_if.data, 8'h77);

      // Back-to-back frames
      vt_q.delete();
      send_frame(8'h00, 1'b1, BIT_CLK, 1'b1);
      send_frame(8'hFF, 1'b1, BIT_CLK, 1'b1);
      idle(BIT_CLK);
      check("b2b_count", vt_q.size(), 2);
      if (vt_q.size() == 2) check_range("b2b_spacing", vt_q[1] - vt_q[0], B2B - B2B_TOL, B2B + B2B_TOL);
      check("b2b_ff", rx_if.data, 8'hFF);

      // Reset during data bit 3 of 0x96
      @(negedge CLK100MHZ);
      RXD = 1'b0;
      repeat (BIT_CLK - 1) @(negedge CLK100MHZ);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK100MHZ);
         RXD = (8'h96 >> i) & 8'h01;
         repeat (BIT_CLK - 1) @(negedge CLK100MHZ);
      end
      @(negedge CLK100MHZ);
      RXD = 1'b0;
      repeat (BIT_CLK / 2) @(negedge CLK100MHZ);
      reset = 1'b1;
      #1;
      check("midrst_data", rx_if.data, 8'h00);
      check("midrst_busy", rx_if.busy, 1'b0);
      check("midrst_valid", rx_if.valid, 1'b0);
      repeat (10) @(negedge CLK100MHZ);
      RXD = 1'b1;
      repeat (5) @(negedge CLK100MHZ);
      reset = 1'b0;
      idle(BIT_CLK);
      send_frame(8'h5A, 1'b1, BIT_CLK, 1'b1);
      idle(BIT_CLK);
      check("after_rst_5a", rx_if.data, 8'h5A);

      // Baud tolerance +3% / -3%
      send_frame(8'hC3, 1'b1, 447, 1'b1);
      idle(BIT_CLK);
      check("tol_plus_c3", rx_if.data, 8'hC3);
      send_frame(8'h3C, 1'b1, BIT_CLK, 1'b1);
      send_frame(8'hC3, 1'b1, 421, 1'b1);
      idle(BIT_CLK);
      check("tol_minus_c3", rx_if.data, 8'hC3);

      repeat (20) @(negedge CLK100MHZ);
      check("expected_queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
